// File: rtl/id_hazard_forward_ctrl.sv
// ID-stage operand forwarding and hazard controller.
// Picks the nearest producer (EX > MEM > WB) for each of NUM_SRC source operands.
// Sequences load-use stalls and data-memory wait freezes.
// Optional build macro: HAZARD_STATS_EN adds bubble/freeze cycle counters.
module id_hazard_forward_ctrl #(
  parameter int REG_AW     = 2,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic                      ex_wr_en,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_is_load,
  input  logic                      mem_wr_en,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_ready,
  input  logic                      wb_wr_en,
  input  logic [REG_AW-1:0]         wb_rd,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic                      freeze,
  output logic [1:0]                fsm_state
`ifdef HAZARD_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [15:0]               stat_lu,
  output logic [15:0]               stat_mem
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(LOAD_STALL - 1);

  state_t state, state_nx;
  state_t saved, saved_nx;
  logic [2:0] cnt, cnt_nx;

  logic [NUM_SRC-1:0][REG_AW-1:0] addr;
  logic [NUM_SRC-1:0] match_ex, match_mem, match_wb;
  logic lu;

  assign addr = src_addr;

  // Per-operand producer match against each downstream stage.
  always_comb begin
    match_ex  = '0;
    match_mem = '0;
    match_wb  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (src_used[i] && !((ZERO_REG != 0) && (addr[i] == '0))) begin
        match_ex[i]  = ex_wr_en  && (addr[i] == ex_rd);
        match_mem[i] = mem_wr_en && (addr[i] == mem_rd);
        match_wb[i]  = wb_wr_en  && (addr[i] == wb_rd);
      end
    end
  end

  assign lu = |match_ex && ex_is_load;

  // Forward select: nearest non-load producer wins, held at 0 during reset.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (reset_n) begin
        if (match_ex[i] && !ex_is_load) fwd_sel[2*i +: 2] = 2'b11;
        else if (match_mem[i])          fwd_sel[2*i +: 2] = 2'b10;
        else if (match_wb[i])           fwd_sel[2*i +: 2] = 2'b01;
      end
    end
  end

  // State, saved state and load-use counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      saved <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      saved <= saved_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic. The counter holds the LU_STALL cycles still owed; the
  // RUN detect cycle already supplied one, so LOAD_STALL=1 never enters LU_STALL.
  always_comb begin
    state_nx = state;
    saved_nx = saved;
    cnt_nx   = cnt;
    if (!mem_ready) begin
      state_nx = MEM_WAIT;
      if (state != MEM_WAIT) saved_nx = state;
    end else begin
      case (state)
        MEM_WAIT: begin
          state_nx = saved;
          saved_nx = RUN;
        end
        RUN: begin
          if (lu && (LOAD_STALL > 1)) begin
            state_nx = LU_STALL;
            cnt_nx   = CNT_INIT;
          end
        end
        LU_STALL: begin
          cnt_nx = cnt - 3'd1;
          if (cnt_nx == '0) state_nx = RUN;
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Pipeline control outputs decoded from the current state.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    freeze = 1'b0;
    if (reset_n) begin
      case (state)
        RUN: begin
          stall  = lu;
          bubble = lu;
        end
        LU_STALL: begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
        MEM_WAIT: begin
          stall  = 1'b1;
          freeze = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign fsm_state = state;

`ifdef HAZARD_STATS_EN
  // Saturating counts of bubble and freeze cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lu  <= '0;
      stat_mem <= '0;
    end else if (stat_clr) begin
      stat_lu  <= '0;
      stat_mem <= '0;
    end else begin
      if (bubble && (stat_lu != '1))  stat_lu  <= stat_lu + 16'd1;
      if (freeze && (stat_mem != '1)) stat_mem <= stat_mem + 16'd1;
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_id_hazard_forward_ctrl.sv
// Directed bench for id_hazard_forward_ctrl.
// u_dut: LOAD_STALL=2, ZERO_REG=1; u_dut1: LOAD_STALL=1, ZERO_REG=0; inputs shared.
// HAZARD_STATS_EN builds additionally check the statistics counters.
module tb_id_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] src_addr;
  logic [1:0] src_used;
  logic       ex_wr_en, ex_is_load, mem_wr_en, mem_ready, wb_wr_en;
  logic [1:0] ex_rd, mem_rd, wb_rd;

  logic [3:0] fwd_sel, fwd_sel1;
  logic       stall, bubble, freeze, stall1, bubble1, freeze1;
  logic [1:0] fsm_state, fsm_state1;
`ifdef HAZARD_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_lu, stat_mem, stat_lu1, stat_mem1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_hazard_forward_ctrl #(.REG_AW(2), .NUM_SRC(2), .LOAD_STALL(2), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .src_addr(src_addr), .src_used(src_used),
    .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_ready(mem_ready),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
    .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble), .freeze(freeze),
    .fsm_state(fsm_state)
`ifdef HAZARD_STATS_EN
    , .stat_clr(stat_clr), .stat_lu(stat_lu), .stat_mem(stat_mem)
`endif
  );

  id_hazard_forward_ctrl #(.REG_AW(2), .NUM_SRC(2), .LOAD_STALL(1), .ZERO_REG(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .src_addr(src_addr), .src_used(src_used),
    .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_ready(mem_ready),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
    .fwd_sel(fwd_sel1), .stall(stall1), .bubble(bubble1), .freeze(freeze1),
    .fsm_state(fsm_state1)
`ifdef HAZARD_STATS_EN
    , .stat_clr(stat_clr), .stat_lu(stat_lu1), .stat_mem(stat_mem1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    src_addr = '0; src_used = '0;
    ex_wr_en = 1'b0; ex_rd = '0; ex_is_load = 1'b0;
    mem_wr_en = 1'b0; mem_rd = '0; mem_ready = 1'b1;
    wb_wr_en = 1'b0; wb_rd = '0;
  endtask

  // Load in EX writing r3, read by operand 1.
  task automatic load_use();
    idle();
    ex_wr_en = 1'b1; ex_rd = 2'd3; ex_is_load = 1'b1;
    src_addr = {2'd3, 2'd0}; src_used = 2'b10;
  endtask

  initial begin
    // Reset, with inputs that would otherwise raise lu and a forward.
    reset_n = 1'b0;
    idle();
`ifdef HAZARD_STATS_EN
    stat_clr = 1'b0;
`endif
    ex_wr_en = 1'b1; ex_rd = 2'd1; ex_is_load = 1'b1;
    mem_wr_en = 1'b1; mem_rd = 2'd2;
    src_addr = {2'd2, 2'd1}; src_used = 2'b11;
    #2;
    check("rst_state", fsm_state, 2'b00);
    check("rst_stall", stall, 1'b0);
    check("rst_bubble", bubble, 1'b0);
    check("rst_freeze", freeze, 1'b0);
    check("rst_fwd", fwd_sel, 4'b0000);
    idle();
    #1 reset_n = 1'b1;
    tick();

    // EX non-load forward on operand 0.
    ex_wr_en = 1'b1; ex_rd = 2'd2; src_addr = {2'd0, 2'd2}; src_used = 2'b01;
    #1;
    check("ex_fwd", fwd_sel, 4'b0011);
    check("ex_fwd_stall", stall, 1'b0);
    check("ex_fwd_d1", fwd_sel1, 4'b0011);
    tick();

    // EX, MEM, WB all write r1: EX priority on both operands.
    idle();
    ex_wr_en = 1'b1; ex_rd = 2'd1; mem_wr_en = 1'b1; mem_rd = 2'd1;
    wb_wr_en = 1'b1; wb_rd = 2'd1; src_addr = {2'd1, 2'd1}; src_used = 2'b11;
    #1;
    check("prio_ex", fwd_sel, 4'b1111);
    tick();

    // Operand 0 from MEM, operand 1 from EX.
    idle();
    ex_wr_en = 1'b1; ex_rd = 2'd2; mem_wr_en = 1'b1; mem_rd = 2'd1;
    wb_wr_en = 1'b1; wb_rd = 2'd1; src_addr = {2'd2, 2'd1}; src_used = 2'b11;
    #1;
    check("mix_mem_ex", fwd_sel, 4'b1110);
    tick();

    // Operand 1 from WB; operand 0 matches MEM but is not used.
    idle();
    mem_wr_en = 1'b1; mem_rd = 2'd1; wb_wr_en = 1'b1; wb_rd = 2'd3;
    src_addr = {2'd3, 2'd1}; src_used = 2'b10;
    #1;
    check("wb_unused", fwd_sel, 4'b0100);
    tick();

    // r0 load: blocked on ZERO_REG=1, a real load-use when ZERO_REG=0.
    idle();
    ex_wr_en = 1'b1; ex_rd = 2'd0; ex_is_load = 1'b1;
    src_addr = {2'd0, 2'd0}; src_used = 2'b01;
    #1;
    check("zr_fwd", fwd_sel, 4'b0000);
    check("zr_stall", stall, 1'b0);
    check("nzr_stall", stall1, 1'b1);
    check("nzr_fwd", fwd_sel1, 4'b0000);
    tick();
    idle();
    #1;
    check("zr_state", fsm_state, 2'b00);
    check("ls1_state", fsm_state1, 2'b00);
    check("ls1_stall_end", stall1, 1'b0);
    tick();

    // Load-use: 2 stall cycles with LOAD_STALL=2, 1 with LOAD_STALL=1.
    load_use();
    #1;
    check("lu_a_stall", stall, 1'b1);
    check("lu_a_bubble", bubble, 1'b1);
    check("lu_a_state", fsm_state, 2'b00);
    check("lu_a_fwd", fwd_sel, 4'b0000);
    check("lu_a_stall1", stall1, 1'b1);
    tick();
    idle();
    mem_wr_en = 1'b1; mem_rd = 2'd3; src_addr = {2'd3, 2'd0}; src_used = 2'b10;
    #1;
    check("lu_b_state", fsm_state, 2'b01);
    check("lu_b_stall", stall, 1'b1);
    check("lu_b_bubble", bubble, 1'b1);
    check("lu_b_state1", fsm_state1, 2'b00);
    check("lu_b_stall1", stall1, 1'b0);
    check("lu_b_fwd1", fwd_sel1, 4'b1000);
    tick();
    #1;
    check("lu_c_state", fsm_state, 2'b00);
    check("lu_c_stall", stall, 1'b0);
    check("lu_c_fwd", fwd_sel, 4'b1000);
    idle();
    tick();

    // Memory wait of 3 cycles inside LU_STALL; counter preserved.
    load_use();
    tick();
    idle(); mem_ready = 1'b0;
    #1;
    check("mw_b_state", fsm_state, 2'b01);
    tick();
    #1;
    check("mw_c_state", fsm_state, 2'b10);
    check("mw_c_freeze", freeze, 1'b1);
    check("mw_c_stall", stall, 1'b1);
    check("mw_c_bubble", bubble, 1'b0);
    check("mw_c_state1", fsm_state1, 2'b10);
    tick();
    #1;
    check("mw_d_freeze", freeze, 1'b1);
    tick();
    mem_ready = 1'b1;
    #1;
    check("mw_e_freeze", freeze, 1'b1);
    check("mw_e_state", fsm_state, 2'b10);
    tick();
    #1;
    check("mw_f_state", fsm_state, 2'b01);
    check("mw_f_bubble", bubble, 1'b1);
    check("mw_f_freeze", freeze, 1'b0);
    check("mw_f_state1", fsm_state1, 2'b00);
    tick();
    #1;
    check("mw_g_state", fsm_state, 2'b00);
    check("mw_g_stall", stall, 1'b0);
    tick();

    // lu together with mem_ready=0: wait first, lu re-evaluated afterwards.
    load_use(); mem_ready = 1'b0;
    #1;
    check("sim_a_stall", stall, 1'b1);
    tick();
    mem_ready = 1'b1;
    #1;
    check("sim_b_state", fsm_state, 2'b10);
    check("sim_b_freeze", freeze, 1'b1);
    tick();
    #1;
    check("sim_c_state", fsm_state, 2'b00);
    check("sim_c_stall", stall, 1'b1);
    tick();
    idle();
    #1;
    check("sim_d_state", fsm_state, 2'b01);
    tick();
    #1;
    check("sim_e_state", fsm_state, 2'b00);
    tick();

    // Statistics clear and counting, then reset in the middle of LU_STALL.
`ifdef HAZARD_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    check("stat_clr_lu", stat_lu, 16'd0);
    check("stat_clr_mem", stat_mem, 16'd0);
`endif
    load_use();
    tick();
    idle(); mem_ready = 1'b0;
    tick();
    mem_ready = 1'b1;
    #1;
    check("st_wait_state", fsm_state, 2'b10);
`ifdef HAZARD_STATS_EN
    check("stat_lu_2", stat_lu, 16'd2);
    check("stat_mem_0", stat_mem, 16'd0);
`endif
    tick();
    load_use();
    mem_wr_en = 1'b1; mem_rd = 2'd1; src_addr = {2'd3, 2'd1}; src_used = 2'b11;
    #1;
    check("pre_rst_state", fsm_state, 2'b01);
    check("pre_rst_fwd", fwd_sel, 4'b0010);
`ifdef HAZARD_STATS_EN
    check("stat_mem_1", stat_mem, 16'd1);
`endif
    reset_n = 1'b0;
    #1;
    check("arst_state", fsm_state, 2'b00);
    check("arst_stall", stall, 1'b0);
    check("arst_bubble", bubble, 1'b0);
    check("arst_freeze", freeze, 1'b0);
    check("arst_fwd", fwd_sel, 4'b0000);
`ifdef HAZARD_STATS_EN
    check("arst_stat_lu", stat_lu, 16'd0);
    check("arst_stat_mem", stat_mem, 16'd0);
`endif
    idle();
    #1 reset_n = 1'b1;
    tick();
    #1;
    check("post_rst_state", fsm_state, 2'b00);
    check("post_rst_stall", stall, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
